// File: rtl/m16_seq_ctrl.sv
// Iterative 16x16 multiply sequencer: four 8x8 partial products through one shared
// external multiplier of depth MUL_LAT, accumulated into a 32-bit result.
module m16_seq_ctrl #(
    parameter int MUL_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_a,
    input  logic [15:0] in_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_y,
    output logic [7:0]  mul_a,
    output logic [7:0]  mul_b,
    input  logic [15:0] mul_y,
    output logic        busy
);

    // state | meaning
    // IDLE  | waiting for a request, in_ready high
    // RUN   | issuing partial products and accumulating captures
    // DONE  | result held on out_y until the consumer takes it
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state_q, state_d;
    logic [15:0] a_q, a_d, b_q, b_d;
    logic [1:0]  issue_cnt_q, issue_cnt_d, cap_cnt_q, cap_cnt_d;
    logic        issue_vld_q, issue_vld_d;
    logic [1:0]  tag_q, tag_d;
    logic [31:0] acc_q, acc_d, out_y_q, out_y_d;
    logic        out_valid_q, out_valid_d;
    logic [7:0]  mul_a_q, mul_a_d, mul_b_q, mul_b_d;
    logic        busy_q, busy_d, in_ready_q, in_ready_d;
    logic        cap_vld;
    logic [31:0] part;

    // Tag bit marks a freshly issued pair; it is delayed to line up with mul_y.
    always_comb begin
        case (MUL_LAT)
            0:       cap_vld = issue_vld_q;
            1:       cap_vld = tag_q[0];
            default: cap_vld = tag_q[1];
        endcase
    end

    always_comb begin
        case (cap_cnt_q)
            2'd0:    part = {16'h0000, mul_y};
            2'd3:    part = {mul_y, 16'h0000};
            default: part = {8'h00, mul_y, 8'h00};
        endcase
    end

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        issue_cnt_d = issue_cnt_q;
        cap_cnt_d   = cap_cnt_q;
        issue_vld_d = issue_vld_q;
        tag_d       = {tag_q[0], issue_vld_q};
        acc_d       = acc_q;
        out_y_d     = out_y_q;
        out_valid_d = out_valid_q;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d         = in_a;
                    b_d         = in_b;
                    acc_d       = 32'h0;
                    issue_cnt_d = 2'd0;
                    cap_cnt_d   = 2'd0;
                    issue_vld_d = 1'b1;
                    tag_d       = 2'b00;
                    mul_a_d     = in_a[7:0];
                    mul_b_d     = in_b[7:0];
                    state_d     = RUN;
                end
            end
            RUN: begin
                if (issue_vld_q) begin
                    if (issue_cnt_q == 2'd3) begin
                        issue_vld_d = 1'b0;
                    end else begin
                        issue_cnt_d = issue_cnt_q + 2'd1;
                        case (issue_cnt_q)
                            2'd0: begin
                                mul_a_d = a_q[7:0];
                                mul_b_d = b_q[15:8];
                            end
                            2'd1: begin
                                mul_a_d = a_q[15:8];
                                mul_b_d = b_q[7:0];
                            end
                            default: begin
                                mul_a_d = a_q[15:8];
                                mul_b_d = b_q[15:8];
                            end
                        endcase
                    end
                end
                if (cap_vld) begin
                    acc_d     = acc_q + part;
                    cap_cnt_d = cap_cnt_q + 2'd1;
                    if (cap_cnt_q == 2'd3) begin
                        out_y_d     = acc_q + part;
                        out_valid_d = 1'b1;
                        state_d     = DONE;
                    end
                end
            end
            default: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
        endcase
        in_ready_d = (state_d == IDLE);
        busy_d     = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= 16'h0;
            b_q         <= 16'h0;
            issue_cnt_q <= 2'd0;
            cap_cnt_q   <= 2'd0;
            issue_vld_q <= 1'b0;
            tag_q       <= 2'b00;
            acc_q       <= 32'h0;
            out_y_q     <= 32'h0;
            out_valid_q <= 1'b0;
            mul_a_q     <= 8'h0;
            mul_b_q     <= 8'h0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            issue_cnt_q <= issue_cnt_d;
            cap_cnt_q   <= cap_cnt_d;
            issue_vld_q <= issue_vld_d;
            tag_q       <= tag_d;
            acc_q       <= acc_d;
            out_y_q     <= out_y_d;
            out_valid_q <= out_valid_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            busy_q      <= busy_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_y     = out_y_q;
    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign busy      = busy_q;

endmodule
